// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream multiplexer with one registered
// output stage. The channel is picked either by round-robin arbitration or by
// a legacy fixed select index, chosen at run time through mode_fixed.
//
// Optional feature, macro STREAM_MUX_LAST_EN: adds in_last/out_last so that a
// multi-beat packet on one channel keeps the round-robin grant until its last
// beat. With the macro undefined every beat is treated as a last beat.
module stream_mux_rr #(
  parameter  int WIDTH = 32,
  parameter  int N_IN  = 3,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_fixed,
  input  logic [SEL_W-1:0]      fixed_sel,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready,
  output logic                  sel_err
`ifdef STREAM_MUX_LAST_EN
  ,
  input  logic [N_IN-1:0]       in_last,
  output logic                  out_last
`endif
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
  logic              sel_err_q,   sel_err_d;
  logic [SEL_W-1:0]  ptr_q,       ptr_d;
`ifdef STREAM_MUX_LAST_EN
  logic              out_last_q,  out_last_d;
  logic              lock_q,      lock_d;
  logic [SEL_W-1:0]  lock_ch_q,   lock_ch_d;
`endif

  logic              slot_free;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant;
  logic              sel_bad;
  logic              xfer;
  logic              beat_last;
  logic [SEL_W-1:0]  grant_next;
  logic [WIDTH-1:0]  sel_data;

  // The output register can take a new beat when empty or being drained now.
  assign slot_free = ~out_valid_q | out_ready;

  // Pick the granted channel: fixed index, locked packet channel, or the first
  // valid channel at or after the round-robin pointer.
  always_comb begin : grant_logic
    int sum;
    grant       = '0;
    grant_valid = 1'b0;
    sel_bad     = 1'b0;
    sum         = 0;
    if (mode_fixed) begin
      if (32'(fixed_sel) >= N_IN) begin
        sel_bad = 1'b1;
      end else begin
        grant       = fixed_sel;
        grant_valid = in_valid[fixed_sel];
      end
`ifdef STREAM_MUX_LAST_EN
    end else if (lock_q) begin
      grant       = lock_ch_q;
      grant_valid = in_valid[lock_ch_q];
`endif
    end else begin
      // Walk from farthest to nearest so the channel closest to ptr wins.
      for (int k = N_IN - 1; k >= 0; k--) begin
        sum = int'(ptr_q) + k;
        if (sum >= N_IN) sum = sum - N_IN;
        if (in_valid[SEL_W'(sum)]) begin
          grant       = SEL_W'(sum);
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Only the granted channel sees ready, and only when the slot can accept.
  always_comb begin
    in_ready = '0;
    if (slot_free && grant_valid) in_ready = N_IN'(1) << grant;
  end

  // Route the granted channel's data toward the output register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant == SEL_W'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign xfer       = slot_free & grant_valid;
  assign grant_next = (grant == SEL_W'(N_IN - 1)) ? '0 : grant + SEL_W'(1);
`ifdef STREAM_MUX_LAST_EN
  assign beat_last  = in_last[grant];
`else
  assign beat_last  = 1'b1;
`endif

  // Next-state for the output stage, pointer, packet lock and error flag.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    sel_err_d   = sel_err_q | sel_bad;
`ifdef STREAM_MUX_LAST_EN
    out_last_d  = out_last_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = grant;
`ifdef STREAM_MUX_LAST_EN
      out_last_d  = beat_last;
`endif
      if (!mode_fixed) begin
        if (beat_last) begin
          ptr_d = grant_next;
`ifdef STREAM_MUX_LAST_EN
          lock_d = 1'b0;
        end else begin
          lock_d    = 1'b1;
          lock_ch_d = grant;
`endif
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; an asynchronous reset drops any held beat at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      sel_err_q   <= 1'b0;
      ptr_q       <= '0;
`ifdef STREAM_MUX_LAST_EN
      out_last_q  <= 1'b0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      sel_err_q   <= sel_err_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LAST_EN
      out_last_q  <= out_last_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign sel_err   = sel_err_q;
`ifdef STREAM_MUX_LAST_EN
  assign out_last  = out_last_q;
`endif

endmodule
